serial_digit_adder: RTL

Multi-cycle, digit-serial adder/subtractor: the parametrised successor to the team's gate-level ripple-carry adder. Each operand pair is accepted through a valid/ready handshake and processed DIGIT bits per clock, least-significant digit first, with the carry held in a register between digits. The block trades latency for area in datapaths where a full-width ripple chain would not close timing. It sits between an operand-producing stage and a result consumer, with independent backpressure on each side.

---
 rtl/serial_digit_adder.sv | 108 ++++++++++
 1 files changed

// File: rtl/serial_digit_adder.sv
// serial_digit_adder: digit-serial adder/subtractor that sums DIGIT bits per clock,
// least-significant digit first, with the inter-digit carry held in a register.
module serial_digit_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CNTW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] accnxt;
    logic [CNTW-1:0]  cnt;
    logic             carry;
    logic [DIGIT:0]   dtotal;
    logic [DIGIT-1:0] dsum;
    logic             dcarry;
    logic             msbcarry;
    logic             accept;
    logic             lastdig;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = BUSY;
            BUSY:    if (lastdig) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // One DIGIT-wide ripple slice; the carry into the top bit of the slice is
    // recovered from the sum bit so overflow needs no extra adder.
    always_comb begin
        accept   = in_ready && in_valid;
        lastdig  = (cnt == LAST);
        dtotal   = {1'b0, areg[DIGIT-1:0]} + {1'b0, breg[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
        dsum     = dtotal[DIGIT-1:0];
        dcarry   = dtotal[DIGIT];
        msbcarry = areg[DIGIT-1] ^ breg[DIGIT-1] ^ dsum[DIGIT-1];
        accnxt   = (acc >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
    end

    // The partial result builds up in acc so that s only changes when a result completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            areg  <= '0;
            breg  <= '0;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            areg  <= a;
            breg  <= sub ? ~b : b;
            carry <= cin ^ sub;
            cnt   <= '0;
        end else if (state == BUSY) begin
            areg  <= areg >> DIGIT;
            breg  <= breg >> DIGIT;
            acc   <= accnxt;
            carry <= dcarry;
            cnt   <= cnt + 1'b1;
            if (lastdig) begin
                s    <= accnxt;
                cout <= dcarry;
                ovf  <= msbcarry ^ dcarry;
            end
        end
    end

endmodule
